// File: rtl/ex_mem_pkg.sv
// Shared constants and payload type for the EX->MEM pipeline register.
package ex_mem_pkg;

    localparam int unsigned REG_W       = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned DREG_W      = 64;
    localparam int unsigned ALUOP_W     = 8;
    localparam int unsigned STALL_W     = 6;

    localparam logic                  RST_ENABLE    = 1'b1;
    localparam logic                  STOP          = 1'b1;
    localparam logic                  NO_STOP       = 1'b0;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [ALUOP_W-1:0]    EXE_NOP_OP    = '0;

    // Everything that travels from EX into MEM as one unit.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      wdata;
        logic                  whilo;
        logic [REG_W-1:0]      hi;
        logic [REG_W-1:0]      lo;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_W-1:0]      mem_addr;
        logic [REG_W-1:0]      reg2;
    } ex_mem_payload_t;

    // The payload that makes MEM perform no work.
    localparam ex_mem_payload_t PAYLOAD_NOP = '{
        wd:       NOP_REG_ADDR,
        wreg:     WRITE_DISABLE,
        wdata:    ZERO_WORD,
        whilo:    WRITE_DISABLE,
        hi:       ZERO_WORD,
        lo:       ZERO_WORD,
        aluop:    EXE_NOP_OP,
        mem_addr: ZERO_WORD,
        reg2:     ZERO_WORD
    };

endpackage

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/flush handling and the madd/msub
// accumulator that EX feeds back to itself across multi-cycle operations.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int unsigned EX_STALL_IDX  = 3,
    parameter int unsigned MEM_STALL_IDX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic                  ex_whilo,
    input  logic [REG_W-1:0]      ex_hi,
    input  logic [REG_W-1:0]      ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [REG_W-1:0]      ex_mem_addr,
    input  logic [REG_W-1:0]      ex_reg2,
    input  logic [DREG_W-1:0]     hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [REG_W-1:0]      mem_wdata,
    output logic                  mem_whilo,
    output logic [REG_W-1:0]      mem_hi,
    output logic [REG_W-1:0]      mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [REG_W-1:0]      mem_mem_addr,
    output logic [REG_W-1:0]      mem_reg2,
    output logic [DREG_W-1:0]     hilo_o,
    output logic [1:0]            cnt_o
);

    ex_mem_payload_t       payload_q;
    ex_mem_payload_t       payload_d;
    logic [DREG_W-1:0]     hilo_q;
    logic [1:0]            cnt_q;
    logic                  ex_stall;
    logic                  mem_stall;

    // Only two stall bits matter here; the rest belong to other stages.
    logic                  unused_stall;
    assign unused_stall = ^stall;

    assign ex_stall  = stall[EX_STALL_IDX];
    assign mem_stall = stall[MEM_STALL_IDX];

    // Gather the EX-side payload into one struct.
    always_comb begin
        payload_d          = PAYLOAD_NOP;
        payload_d.wd       = ex_wd;
        payload_d.wreg     = ex_wreg;
        payload_d.wdata    = ex_wdata;
        payload_d.whilo    = ex_whilo;
        payload_d.hi       = ex_hi;
        payload_d.lo       = ex_lo;
        payload_d.aluop    = ex_aluop;
        payload_d.mem_addr = ex_mem_addr;
        payload_d.reg2     = ex_reg2;
    end

    // Mode decode in priority order: reset, flush, bubble, hold, advance.
    // A MEM stall without an EX stall is non-monotone and falls into hold.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            payload_q <= PAYLOAD_NOP;
            hilo_q    <= '0;
            cnt_q     <= '0;
        end else if (flush) begin
            payload_q <= PAYLOAD_NOP;
            hilo_q    <= '0;
            cnt_q     <= '0;
        end else if (ex_stall == STOP && mem_stall == NO_STOP) begin
            payload_q <= PAYLOAD_NOP;
            hilo_q    <= hilo_i;
            cnt_q     <= cnt_i;
        end else if (ex_stall == STOP || mem_stall == STOP) begin
            hilo_q    <= hilo_i;
            cnt_q     <= cnt_i;
        end else begin
            payload_q <= payload_d;
            hilo_q    <= '0;
            cnt_q     <= '0;
        end
    end

    assign mem_wd       = payload_q.wd;
    assign mem_wreg     = payload_q.wreg;
    assign mem_wdata    = payload_q.wdata;
    assign mem_whilo    = payload_q.whilo;
    assign mem_hi       = payload_q.hi;
    assign mem_lo       = payload_q.lo;
    assign mem_aluop    = payload_q.aluop;
    assign mem_mem_addr = payload_q.mem_addr;
    assign mem_reg2     = payload_q.reg2;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for the EX->MEM pipeline register.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int unsigned tests = 0;
    int unsigned fails = 0;

    ex_mem #(
        .EX_STALL_IDX (3),
        .MEM_STALL_IDX(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_whilo    (ex_whilo),
        .ex_hi       (ex_hi),
        .ex_lo       (ex_lo),
        .ex_aluop    (ex_aluop),
        .ex_mem_addr (ex_mem_addr),
        .ex_reg2     (ex_reg2),
        .hilo_i      (hilo_i),
        .cnt_i       (cnt_i),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_whilo   (mem_whilo),
        .mem_hi      (mem_hi),
        .mem_lo      (mem_lo),
        .mem_aluop   (mem_aluop),
        .mem_mem_addr(mem_mem_addr),
        .mem_reg2    (mem_reg2),
        .hilo_o      (hilo_o),
        .cnt_o       (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag,
                             input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                             input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                             input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2,
                             input logic [63:0] hilo, input logic [1:0] cnt);
        check({tag, ".wd"},    64'(mem_wd),       64'(wd));
        check({tag, ".wreg"},  64'(mem_wreg),     64'(wreg));
        check({tag, ".wdata"}, 64'(mem_wdata),    64'(wdata));
        check({tag, ".whilo"}, 64'(mem_whilo),    64'(whilo));
        check({tag, ".hi"},    64'(mem_hi),       64'(hi));
        check({tag, ".lo"},    64'(mem_lo),       64'(lo));
        check({tag, ".aluop"}, 64'(mem_aluop),    64'(aluop));
        check({tag, ".addr"},  64'(mem_mem_addr), 64'(addr));
        check({tag, ".reg2"},  64'(mem_reg2),     64'(reg2));
        check({tag, ".hilo"},  hilo_o,            hilo);
        check({tag, ".cnt"},   64'(cnt_o),        64'(cnt));
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_whilo = whilo;
        ex_hi = hi; ex_lo = lo; ex_aluop = aluop; ex_mem_addr = addr; ex_reg2 = reg2;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with random EX-side inputs.
        rst = 1'b1; flush = 1'b0; stall = 6'b000000;
        set_ex(5'($urandom), 1'b1, $urandom, 1'b1, $urandom, $urandom, 8'($urandom), $urandom, $urandom);
        hilo_i = {$urandom, $urandom}; cnt_i = 2'b11;
        step();
        set_ex(5'($urandom), 1'b1, $urandom, 1'b1, $urandom, $urandom, 8'($urandom), $urandom, $urandom);
        step();
        check_all("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 64'h0, 2'b00);

        // Advance: payload appears one cycle later, accumulator cleared.
        rst = 1'b0;
        set_ex(5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h11111111, 32'h22222222, 8'h20, 32'h00000100, 32'h0000CAFE);
        hilo_i = 64'h77; cnt_i = 2'b10;
        step();
        check_all("advance", 5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h11111111, 32'h22222222, 8'h20,
                  32'h00000100, 32'h0000CAFE, 64'h0, 2'b00);

        // Bubble: NOP enters MEM, accumulator captured.
        stall = 6'b001111;
        set_ex(5'd9, 1'b1, 32'h00001234, 1'b1, 32'h5, 32'h6, 8'h21, 32'h200, 32'h300);
        hilo_i = 64'hA5; cnt_i = 2'b01;
        step();
        check_all("bubble", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 64'hA5, 2'b01);

        // Load 0x55, then hold for three cycles while inputs change.
        stall = 6'b000000;
        set_ex(5'd7, 1'b1, 32'h00000055, 1'b0, 32'h0, 32'h0, 8'h22, 32'h44, 32'h88);
        step();
        check("load55.wdata", 64'(mem_wdata), 64'h55);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(10 + i), 1'b0, 32'h66 + 32'(i), 1'b1, 32'h9, 32'h9, 8'h33, 32'h9, 32'h9);
            hilo_i = 64'h1000 + 64'(i); cnt_i = 2'(i);
            step();
            check_all($sformatf("hold%0d", i), 5'd7, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0, 8'h22,
                      32'h44, 32'h88, 64'h1000 + 64'(i), 2'(i));
        end

        // Non-monotone stall (MEM only) behaves as hold.
        stall = 6'b010000;
        set_ex(5'd1, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        hilo_i = 64'hBEEF; cnt_i = 2'b11;
        step();
        check("nonmono.wdata", 64'(mem_wdata), 64'h55);
        check("nonmono.wd",    64'(mem_wd),    64'd7);
        check("nonmono.hilo",  hilo_o,         64'hBEEF);
        check("nonmono.cnt",   64'(cnt_o),     64'd3);

        // Two-cycle madd: bubble holds partial product, release commits.
        stall = 6'b001111;
        set_ex(5'd0, 1'b0, 32'h0, 1'b1, 32'h3, 32'h4, 8'hA8, 32'h0, 32'h0);
        hilo_i = 64'h10; cnt_i = 2'b01;
        step();
        check("madd1.cnt",   64'(cnt_o),     64'd1);
        check("madd1.hilo",  hilo_o,         64'h10);
        check("madd1.whilo", 64'(mem_whilo), 64'd0);
        stall = 6'b000000; cnt_i = 2'b10;
        step();
        check("madd2.cnt",   64'(cnt_o),     64'd0);
        check("madd2.hilo",  hilo_o,         64'h0);
        check("madd2.whilo", 64'(mem_whilo), 64'd1);
        check("madd2.hi",    64'(mem_hi),    64'h3);
        check("madd2.lo",    64'(mem_lo),    64'h4);

        // Start another madd, then flush alongside a bubble: flush wins.
        stall = 6'b001111; hilo_i = 64'h20; cnt_i = 2'b01;
        step();
        check("madd3.cnt", 64'(cnt_o), 64'd1);
        flush = 1'b1;
        set_ex(5'd12, 1'b1, 32'hFACE, 1'b1, 32'h7, 32'h8, 8'h24, 32'h10, 32'h20);
        hilo_i = 64'hFF; cnt_i = 2'b01;
        step();
        check_all("flush_bubble", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 64'h0, 2'b00);

        // Flush also overrides hold of a valid payload.
        flush = 1'b0; stall = 6'b000000;
        step();
        check("refill.wdata", 64'(mem_wdata), 64'hFACE);
        flush = 1'b1; stall = 6'b011111; hilo_i = 64'hAB; cnt_i = 2'b10;
        step();
        check_all("flush_hold", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 64'h0, 2'b00);

        // Reset overrides flush=0 advance with valid inputs.
        flush = 1'b0; stall = 6'b000000; rst = 1'b1;
        step();
        check("rst_adv.wreg", 64'(mem_wreg), 64'd0);
        check("rst_adv.wd",   64'(mem_wd),   64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
